// File: rtl/bram_sdp_split_pkg.sv
// Shared definitions for the split-mode SDP BRAM FIFO controller:
// legal BRAM-half geometries, read latency and output-buffer depth.
package bram_sdp_split_pkg;

  localparam int RD_LAT     = 1;
  localparam int OBUF_DEPTH = 2;

  // Aspect ratios supported by one 18K half in SDP mode.
  localparam int unsigned N_GEOM = 7;
  localparam int GEOM_AW [N_GEOM] = '{10, 10, 11, 11, 12, 13, 14};
  localparam int GEOM_DW [N_GEOM] = '{18, 16,  9,  8,  4,  2,  1};

  // Output skid-buffer occupancy.
  typedef enum logic [1:0] {
    OB_EMPTY = 2'd0,
    OB_ONE   = 2'd1,
    OB_TWO   = 2'd2
  } obuf_occ_e;

  function automatic bit is_legal_geom(input int aw, input int dw);
    bit ok;
    ok = 1'b0;
    for (int unsigned i = 0; i < N_GEOM; i++) begin
      if (GEOM_AW[i] == aw && GEOM_DW[i] == dw) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bram_sdp_fifo_chan.sv
// One FIFO channel over one BRAM half: write/read pointers, occupancy
// count, fetch control and a 2-entry output skid buffer.
// Optional almost-full/almost-empty flags: BRAM_FIFO_ALMOST_FLAGS_EN.
module bram_sdp_fifo_chan
  import bram_sdp_split_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 18
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_TH = (1 << AWIDTH) - 4,
  parameter int AE_TH = 4
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst,
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  output logic              o_almost_full,
  output logic              o_almost_empty,
`endif
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DWIDTH-1:0] i_wr_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DWIDTH-1:0] o_rd_data,
  output logic [AWIDTH:0]   o_count,
  output logic              o_rce,
  output logic [AWIDTH-1:0] o_ra,
  input  logic [DWIDTH-1:0] i_rq,
  output logic              o_wce,
  output logic [AWIDTH-1:0] o_wa,
  output logic [DWIDTH-1:0] o_wd
);

  localparam logic [AWIDTH:0] DEPTH      = (AWIDTH+1)'(1) << AWIDTH;
  localparam logic [1:0]      OB_DEPTH_N = 2'(OBUF_DEPTH);

  // The in-flight tracking below is a single stage.
  if (RD_LAT != 1) begin : g_bad_lat
    $error("bram_sdp_fifo_chan supports RD_LAT == 1 only");
  end

  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH:0]   r_count;
  logic [AWIDTH:0]   r_bram_cnt;   // committed entries not yet fetched
  logic              r_wr_ready;
  logic              r_inflight;   // read issued last cycle, data on i_rq now
  obuf_occ_e         r_ob_occ;
  logic [DWIDTH-1:0] r_ob_data [OBUF_DEPTH];

  logic              w_push;
  logic              w_pop;
  logic              w_fetch;
  logic              w_ob_has0;
  logic              w_ob_has1;
  logic              w_rd_valid;
  logic [DWIDTH-1:0] w_head;
  logic [DWIDTH-1:0] w_second;
  logic [1:0]        w_occ_n;
  logic [AWIDTH:0]   w_count_n;
  logic [AWIDTH:0]   w_bram_cnt_n;

  // Handshakes, head selection and fetch decision.
  // The head is taken straight from i_rq while the buffer is empty so the
  // first word appears two cycles after its push; the fetch credit counts
  // this cycle's pop so a continuous pop stream is sustained.
  always_comb begin
    w_push       = i_wr_valid & r_wr_ready;
    w_ob_has0    = (r_ob_occ != OB_EMPTY);
    w_ob_has1    = (r_ob_occ == OB_TWO);
    w_rd_valid   = w_ob_has0 | r_inflight;
    w_pop        = w_rd_valid & i_rd_ready;
    w_head       = w_ob_has0 ? r_ob_data[0] : i_rq;
    w_second     = w_ob_has1 ? r_ob_data[1] : i_rq;
    w_occ_n      = 2'(r_ob_occ) + {1'b0, r_inflight} - {1'b0, w_pop};
    w_fetch      = (r_bram_cnt != '0) && (w_occ_n < OB_DEPTH_N);
    w_count_n    = r_count + (AWIDTH+1)'(w_push) - (AWIDTH+1)'(w_pop);
    w_bram_cnt_n = r_bram_cnt + (AWIDTH+1)'(w_push) - (AWIDTH+1)'(w_fetch);
  end

  // Pointer, count and occupancy state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_bram_cnt <= '0;
      r_wr_ready <= 1'b0;
      r_inflight <= 1'b0;
      r_ob_occ   <= OB_EMPTY;
    end else begin
      if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_fetch) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_n;
      r_bram_cnt <= w_bram_cnt_n;
      r_wr_ready <= (w_count_n < DEPTH);
      r_inflight <= w_fetch;
      r_ob_occ   <= obuf_occ_e'(w_occ_n);
    end
  end

  // Skid-buffer data: shift on pop, land the arriving word behind the head.
  always_ff @(posedge i_clk) begin
    r_ob_data[0] <= w_pop ? w_second : w_head;
    r_ob_data[1] <= w_second;
  end

`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  localparam logic [AWIDTH:0] AF_C = (AWIDTH+1)'(AF_TH);
  localparam logic [AWIDTH:0] AE_C = (AWIDTH+1)'(AE_TH);

  logic r_almost_full;
  logic r_almost_empty;

  // Threshold flags registered from the current count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_almost_full  <= (r_count >= AF_C);
      r_almost_empty <= (r_count <= AE_C);
    end
  end

  assign o_almost_full  = r_almost_full;
  assign o_almost_empty = r_almost_empty;
`endif

  assign o_wr_ready = r_wr_ready;
  assign o_rd_valid = w_rd_valid;
  assign o_rd_data  = w_head;
  assign o_count    = r_count;
  assign o_rce      = w_fetch;
  assign o_ra       = r_rd_ptr;
  assign o_wce      = w_push;
  assign o_wa       = r_wr_ptr;
  assign o_wd       = i_wr_data;

endmodule

// File: rtl/bram_sdp_split_fifo_ctrl.sv
// Two independent synchronous FIFOs on the two halves of one split-mode
// SDP BRAM. Top level: geometry check plus two channel instances.
// Optional almost-full/almost-empty flags: BRAM_FIFO_ALMOST_FLAGS_EN.
module bram_sdp_split_fifo_ctrl
  import bram_sdp_split_pkg::*;
#(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 18
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_TH = (1 << AWIDTH) - 4,
  parameter int AE_TH = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  output logic              almost_full_0,
  output logic              almost_empty_0,
  output logic              almost_full_1,
  output logic              almost_empty_1,
`endif
  input  logic              wr_valid_0,
  output logic              wr_ready_0,
  input  logic [DWIDTH-1:0] wr_data_0,
  output logic              rd_valid_0,
  input  logic              rd_ready_0,
  output logic [DWIDTH-1:0] rd_data_0,
  output logic [AWIDTH:0]   count_0,
  output logic              rce_0,
  output logic [AWIDTH-1:0] ra_0,
  input  logic [DWIDTH-1:0] rq_0,
  output logic              wce_0,
  output logic [AWIDTH-1:0] wa_0,
  output logic [DWIDTH-1:0] wd_0,
  input  logic              wr_valid_1,
  output logic              wr_ready_1,
  input  logic [DWIDTH-1:0] wr_data_1,
  output logic              rd_valid_1,
  input  logic              rd_ready_1,
  output logic [DWIDTH-1:0] rd_data_1,
  output logic [AWIDTH:0]   count_1,
  output logic              rce_1,
  output logic [AWIDTH-1:0] ra_1,
  input  logic [DWIDTH-1:0] rq_1,
  output logic              wce_1,
  output logic [AWIDTH-1:0] wa_1,
  output logic [DWIDTH-1:0] wd_1
);

  if (!is_legal_geom(AWIDTH, DWIDTH)) begin : g_bad_geom
    $error("bram_sdp_split_fifo_ctrl: illegal geometry AWIDTH=%0d DWIDTH=%0d", AWIDTH, DWIDTH);
  end

  bram_sdp_fifo_chan #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
    ,
    .AF_TH  (AF_TH),
    .AE_TH  (AE_TH)
`endif
  ) u_chan0 (
    .i_clk          (clk),
    .i_rst          (rst),
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
    .o_almost_full  (almost_full_0),
    .o_almost_empty (almost_empty_0),
`endif
    .i_wr_valid     (wr_valid_0),
    .o_wr_ready     (wr_ready_0),
    .i_wr_data      (wr_data_0),
    .o_rd_valid     (rd_valid_0),
    .i_rd_ready     (rd_ready_0),
    .o_rd_data      (rd_data_0),
    .o_count        (count_0),
    .o_rce          (rce_0),
    .o_ra           (ra_0),
    .i_rq           (rq_0),
    .o_wce          (wce_0),
    .o_wa           (wa_0),
    .o_wd           (wd_0)
  );

  bram_sdp_fifo_chan #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
    ,
    .AF_TH  (AF_TH),
    .AE_TH  (AE_TH)
`endif
  ) u_chan1 (
    .i_clk          (clk),
    .i_rst          (rst),
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
    .o_almost_full  (almost_full_1),
    .o_almost_empty (almost_empty_1),
`endif
    .i_wr_valid     (wr_valid_1),
    .o_wr_ready     (wr_ready_1),
    .i_wr_data      (wr_data_1),
    .o_rd_valid     (rd_valid_1),
    .i_rd_ready     (rd_ready_1),
    .o_rd_data      (rd_data_1),
    .o_count        (count_1),
    .o_rce          (rce_1),
    .o_ra           (ra_1),
    .i_rq           (rq_1),
    .o_wce          (wce_1),
    .o_wa           (wa_1),
    .o_wd           (wd_1)
  );

endmodule

// File: tb/tb_bram_sdp_split_fifo_ctrl.sv
// Scoreboard bench for bram_sdp_split_fifo_ctrl at 10x18 with a behavioural
// BRAM model per half. Almost-flag checks under BRAM_FIFO_ALMOST_FLAGS_EN.
module tb_bram_sdp_split_fifo_ctrl;

  localparam int AW    = 10;
  localparam int DW    = 18;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_valid_0, wr_ready_0, rd_valid_0, rd_ready_0, rce_0, wce_0;
  logic [DW-1:0] wr_data_0, rd_data_0, rq_0, wd_0;
  logic [AW:0]   count_0;
  logic [AW-1:0] ra_0, wa_0;
  logic          wr_valid_1, wr_ready_1, rd_valid_1, rd_ready_1, rce_1, wce_1;
  logic [DW-1:0] wr_data_1, rd_data_1, rq_1, wd_1;
  logic [AW:0]   count_1;
  logic [AW-1:0] ra_1, wa_1;
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  logic almost_full_0, almost_empty_0, almost_full_1, almost_empty_1;
`endif

  bram_sdp_split_fifo_ctrl #(
    .AWIDTH (AW),
    .DWIDTH (DW)
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
    ,
    .AF_TH  (1020),
    .AE_TH  (4)
`endif
  ) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
    .almost_full_0  (almost_full_0),
    .almost_empty_0 (almost_empty_0),
    .almost_full_1  (almost_full_1),
    .almost_empty_1 (almost_empty_1),
`endif
    .wr_valid_0 (wr_valid_0), .wr_ready_0 (wr_ready_0), .wr_data_0 (wr_data_0),
    .rd_valid_0 (rd_valid_0), .rd_ready_0 (rd_ready_0), .rd_data_0 (rd_data_0),
    .count_0    (count_0),    .rce_0 (rce_0), .ra_0 (ra_0), .rq_0 (rq_0),
    .wce_0      (wce_0),      .wa_0 (wa_0),   .wd_0 (wd_0),
    .wr_valid_1 (wr_valid_1), .wr_ready_1 (wr_ready_1), .wr_data_1 (wr_data_1),
    .rd_valid_1 (rd_valid_1), .rd_ready_1 (rd_ready_1), .rd_data_1 (rd_data_1),
    .count_1    (count_1),    .rce_1 (rce_1), .ra_1 (ra_1), .rq_1 (rq_1),
    .wce_1      (wce_1),      .wa_1 (wa_1),   .wd_1 (wd_1)
  );

  // Behavioural BRAM halves: registered read, output held while rce=0.
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  always @(posedge clk) begin
    if (wce_0) mem0[wa_0] <= wd_0;
    if (rce_0) rq_0 <= mem0[ra_0];
    if (wce_1) mem1[wa_1] <= wd_1;
    if (rce_1) rq_1 <= mem1[ra_1];
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int pops0 = 0;
  int pops1 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; accepted pushes go to the scoreboard.
  task automatic cyc(input logic wv0, input logic [DW-1:0] d0, input logic rr0,
                     input logic wv1, input logic [DW-1:0] d1, input logic rr1);
    @(posedge clk); #1;
    wr_valid_0 = wv0; wr_data_0 = d0; rd_ready_0 = rr0;
    wr_valid_1 = wv1; wr_data_1 = d1; rd_ready_1 = rr1;
    if (wv0 && wr_ready_0 && !rst) q0.push_back(d0);
    if (wv1 && wr_ready_1 && !rst) q1.push_back(d1);
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < maxc) begin
      cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b1);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d words left, expected 0/0", q0.size(), q1.size());
    end
    idle();
    sample();
    check("drain_count0", 64'(count_0), 64'd0);
    check("drain_count1", 64'(count_1), 64'd0);
    check("drain_valid0", 64'(rd_valid_0), 64'd0);
  endtask

  // Monitor: compare every pop against the scoreboard; stalled heads must hold.
  logic          st0_v = 1'b0, st1_v = 1'b0;
  logic [DW-1:0] st0_d, st1_d;
  always @(negedge clk) begin
    if (rst) begin
      st0_v = 1'b0;
      st1_v = 1'b0;
    end else begin
      if (st0_v) begin
        check("hold_valid0", 64'(rd_valid_0), 64'd1);
        check("hold_data0", 64'(rd_data_0), 64'(st0_d));
      end
      if (rd_valid_0 && rd_ready_0) begin
        if (q0.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL pop0_unexpected: got 0x%0h, expected no data", rd_data_0);
        end else begin
          check("pop_data0", 64'(rd_data_0), 64'(q0.pop_front()));
        end
        pops0++;
      end
      st0_v = rd_valid_0 && !rd_ready_0;
      st0_d = rd_data_0;
      if (st1_v) begin
        check("hold_valid1", 64'(rd_valid_1), 64'd1);
        check("hold_data1", 64'(rd_data_1), 64'(st1_d));
      end
      if (rd_valid_1 && rd_ready_1) begin
        if (q1.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL pop1_unexpected: got 0x%0h, expected no data", rd_data_1);
        end else begin
          check("pop_data1", 64'(rd_data_1), 64'(q1.pop_front()));
        end
        pops1++;
      end
      st1_v = rd_valid_1 && !rd_ready_1;
      st1_d = rd_data_1;
    end
  end

`ifdef BRAM_FIFO_ALMOST_FLAGS_EN
  // Flags follow the previous cycle's count against AF_TH=1020 / AE_TH=4.
  int   prev_cnt0 = 0;
  logic prev_rst  = 1'b1;
  always @(negedge clk) begin
    if (!rst && !prev_rst) begin
      check("almost_full0", 64'(almost_full_0), 64'(prev_cnt0 >= 1020));
      check("almost_empty0", 64'(almost_empty_0), 64'(prev_cnt0 <= 4));
    end
    prev_cnt0 = int'(count_0);
    prev_rst  = rst;
  end
`endif

  initial begin
    #3ms;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, p1;
    wr_valid_0 = 0; wr_data_0 = '0; rd_ready_0 = 0;
    wr_valid_1 = 0; wr_data_1 = '0; rd_ready_1 = 0;
    rst = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    sample();
    check("rst_count0", 64'(count_0), 64'd0);
    check("rst_count1", 64'(count_1), 64'd0);
    check("rst_rd_valid0", 64'(rd_valid_0), 64'd0);
    check("rst_rd_valid1", 64'(rd_valid_1), 64'd0);
    check("rst_wr_ready0", 64'(wr_ready_0), 64'd0);
    check("rst_rce0", 64'(rce_0), 64'd0);
    check("rst_wce0", 64'(wce_0), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    idle();
    sample();
    check("wr_ready_after_rst0", 64'(wr_ready_0), 64'd1);
    check("wr_ready_after_rst1", 64'(wr_ready_1), 64'd1);

    // 1: first-word latency
    cyc(1'b1, 18'h3FFFF, 1'b0, 1'b0, '0, 1'b0);
    sample();
    check("t1_wce0", 64'(wce_0), 64'd1);
    check("t1_wa0", 64'(wa_0), 64'd0);
    check("t1_wd0", 64'(wd_0), 64'h3FFFF);
    idle();
    sample();
    check("t1_valid_t1", 64'(rd_valid_0), 64'd0);
    check("t1_rce_t1", 64'(rce_0), 64'd1);
    check("t1_ra_t1", 64'(ra_0), 64'd0);
    idle();
    sample();
    check("t1_valid_t2", 64'(rd_valid_0), 64'd1);
    check("t1_data_t2", 64'(rd_data_0), 64'h3FFFF);
    check("t1_count0", 64'(count_0), 64'd1);
    check("t1_count1", 64'(count_1), 64'd0);
    cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    idle();
    sample();
    check("t1_count0_after_pop", 64'(count_0), 64'd0);
    check("t1_valid_after_pop", 64'(rd_valid_0), 64'd0);

    // 2: fill to full, then push+pop on full
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 18'(i * 3 + 1), 1'b0, 1'b0, '0, 1'b0);
    idle();
    sample();
    check("t2_full_wr_ready", 64'(wr_ready_0), 64'd0);
    check("t2_full_count", 64'(count_0), 64'(DEPTH));
    check("t2_full_valid", 64'(rd_valid_0), 64'd1);
    cyc(1'b1, 18'h2AAAA, 1'b1, 1'b0, '0, 1'b0);
    sample();
    check("t2_full_push_refused", 64'(wce_0), 64'd0);
    idle();
    sample();
    check("t2_count_after_pop", 64'(count_0), 64'(DEPTH - 1));
    check("t2_wr_ready_after_pop", 64'(wr_ready_0), 64'd1);
    drain(2 * DEPTH);

    // 3: streaming both channels, crosses pointer wrap
    p0 = pops0; p1 = pops1;
    for (int i = 0; i < 2100; i++)
      cyc(1'b1, 18'(i * 7 + 5), 1'b1, 1'b1, ~18'(i), 1'b1);
    idle();
    sample();
    check("t3_pops0", 64'(pops0 - p0), 64'd2098);
    check("t3_pops1", 64'(pops1 - p1), 64'd2098);
    check("t3_count0", 64'(count_0), 64'd2);
    check("t3_count1", 64'(count_1), 64'd2);
    drain(100);

    // 4: 50% read backpressure on ch1
    for (int i = 0; i < 3000; i++)
      cyc(1'b0, '0, 1'b0, 1'b1, 18'($urandom), 1'($urandom_range(0, 1)));
    drain(4000);

    // 5: reset with entries stored and a read in flight
    for (int i = 0; i < 37; i++) cyc(1'b1, 18'(i + 100), 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 18'h01234, 1'b1, 1'b0, '0, 1'b0);
    sample();
    check("t5_rce_before_rst", 64'(rce_0), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    wr_valid_0 = 0; rd_ready_0 = 0; wr_valid_1 = 0; rd_ready_1 = 0;
    q0.delete(); q1.delete();
    sample();
    check("t5_count_pre_edge", 64'(count_0), 64'd37);
    @(posedge clk);
    sample();
    check("t5_count_rst", 64'(count_0), 64'd0);
    check("t5_valid_rst", 64'(rd_valid_0), 64'd0);
    @(posedge clk); #1; rst = 1'b0;
    idle();
    cyc(1'b1, 18'h155AA, 1'b0, 1'b0, '0, 1'b0);
    idle();
    idle();
    sample();
    check("t5_new_valid", 64'(rd_valid_0), 64'd1);
    check("t5_new_data", 64'(rd_data_0), 64'h155AA);
    drain(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
